// File: rtl/vdp_vram_arb_if.sv
// Bus bundle for the VRAM arbiter: display fetch port, buffered CPU port and
// the synchronous VRAM macro port. 'slave' is the arbiter's view.
interface vdp_vram_arb_if #(
    parameter int VRAM_ADDR_WIDTH = 13
) ();
    logic [VRAM_ADDR_WIDTH-1:0] vdp_dma_addr;
    logic                       vdp_dma_rd_tick;
    logic [7:0]                 vram_dout;

    logic [VRAM_ADDR_WIDTH-1:0] cpu_addr;
    logic [7:0]                 cpu_wdata;
    logic                       cpu_wr_tick;
    logic                       cpu_rd_tick;
    logic                       cpu_busy;
    logic [7:0]                 cpu_rdata;
    logic                       cpu_done_tick;
    logic                       cpu_overrun_tick;

    logic [VRAM_ADDR_WIDTH-1:0] ram_addr;
    logic                       ram_we;
    logic [7:0]                 ram_din;
    logic [7:0]                 ram_dout;

    modport slave (
        input  vdp_dma_addr, vdp_dma_rd_tick,
        input  cpu_addr, cpu_wdata, cpu_wr_tick, cpu_rd_tick,
        input  ram_dout,
        output vram_dout, cpu_busy, cpu_rdata, cpu_done_tick, cpu_overrun_tick,
        output ram_addr, ram_we, ram_din
    );

    modport master (
        output vdp_dma_addr, vdp_dma_rd_tick,
        output cpu_addr, cpu_wdata, cpu_wr_tick, cpu_rd_tick,
        output ram_dout,
        input  vram_dout, cpu_busy, cpu_rdata, cpu_done_tick, cpu_overrun_tick,
        input  ram_addr, ram_we, ram_din
    );
endinterface

// File: rtl/vdp_vram_arb.sv
// Single-port VRAM arbiter: display fetches own the RAM whenever they tick;
// one buffered CPU access is slotted into the first fetch-free cycle.
module vdp_vram_arb #(
    parameter int VRAM_SIZE       = 8 * 1024,
    parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE)
) (
    input  logic           pxclk,
    input  logic           reset,
    vdp_vram_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PEND, ACC} state_t;

    state_t                     state_q, state_d;
    logic [VRAM_ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]                 buf_wdata_q, buf_wdata_d;
    logic                       buf_wr_q, buf_wr_d;
    logic                       dma_rd_q, dma_rd_d;
    logic [7:0]                 dma_hold_q, dma_hold_d;
    logic [7:0]                 cpu_rdata_q, cpu_rdata_d;
    logic                       overrun_q, overrun_d;

    logic [VRAM_ADDR_WIDTH-1:0] ram_addr;
    logic                       ram_we;
    logic [7:0]                 ram_din;
    logic                       done;
    logic                       cpu_req;

    assign cpu_req = bus.cpu_wr_tick | bus.cpu_rd_tick;
    assign dma_rd_d = bus.vdp_dma_rd_tick;

    always_comb begin
        state_d     = state_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        buf_wr_d    = buf_wr_q;
        cpu_rdata_d = cpu_rdata_q;
        overrun_d   = 1'b0;
        ram_addr    = '0;
        ram_we      = 1'b0;
        ram_din     = '0;
        done        = 1'b0;
        // Fetch data arrives the cycle after its tick, whatever the CPU does.
        dma_hold_d  = dma_rd_q ? bus.ram_dout : dma_hold_q;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    buf_addr_d  = bus.cpu_addr;
                    buf_wdata_d = bus.cpu_wdata;
                    buf_wr_d    = bus.cpu_wr_tick;
                    state_d     = PEND;
                end
            end
            PEND: begin
                overrun_d = cpu_req;
                if (!bus.vdp_dma_rd_tick) begin
                    ram_addr = buf_addr_q;
                    ram_we   = buf_wr_q;
                    ram_din  = buf_wr_q ? buf_wdata_q : 8'h00;
                    state_d  = ACC;
                end
            end
            ACC: begin
                overrun_d = cpu_req;
                done      = 1'b1;
                if (!buf_wr_q) cpu_rdata_d = bus.ram_dout;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Keep the macro address quiet while reset is held.
        if (bus.vdp_dma_rd_tick && reset) begin
            ram_addr = bus.vdp_dma_addr;
            ram_we   = 1'b0;
            ram_din  = '0;
        end
    end

    always_ff @(posedge pxclk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            buf_wr_q    <= 1'b0;
            dma_rd_q    <= 1'b0;
            dma_hold_q  <= '0;
            cpu_rdata_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            buf_wr_q    <= buf_wr_d;
            dma_rd_q    <= dma_rd_d;
            dma_hold_q  <= dma_hold_d;
            cpu_rdata_q <= cpu_rdata_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.vram_dout        = dma_rd_q ? bus.ram_dout : dma_hold_q;
    assign bus.cpu_busy         = (state_q != IDLE);
    assign bus.cpu_rdata        = cpu_rdata_q;
    assign bus.cpu_done_tick    = done;
    assign bus.cpu_overrun_tick = overrun_q;
    assign bus.ram_addr         = ram_addr;
    assign bus.ram_we           = ram_we;
    assign bus.ram_din          = ram_din;
endmodule
